// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// One byte is granted at a time. It is held on tx_data_out until the UART
// reports completion or the transfer times out, and then arbitration runs again.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk_in,
  input  logic                       nrst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*8-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]         req_ack_out,
  output logic [NUM_REQ-1:0]         req_done_out,
  output logic [7:0]                 tx_data_out,
  output logic                       tx_start_out,
  input  logic                       tx_busy_in,
  input  logic                       tx_done_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       active_out,
  output logic                       timeout_err_out
);
  localparam int GW  = $clog2(NUM_REQ);
  localparam int CGW = GW + 1;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_HIT  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]  LAST_RST = GW'(NUM_REQ - 1);
  localparam logic [CGW-1:0] NREQ_C   = CGW'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        gid_q, gid_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 active_q, active_d;
  logic                 terr_q, terr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Per-requester byte view of the flat data bus
  logic [7:0] req_byte [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = req_data_in[8*i +: 8];
  end

  logic           sel_found;
  logic [GW-1:0]  sel_idx;
  logic [CGW-1:0] cand;

  // Rotating-priority scan: first valid requester above the last grant, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_q} + CGW'(off);
      if (cand >= NREQ_C) cand = cand - NREQ_C;
      if (!sel_found && req_valid_in[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  // The counter saturates so that it never wraps. The abort fires on the edge where
  // the count would reach TIMEOUT_CYCLES-1, so start is high for at most that many cycles.
  logic [CW-1:0] cnt_inc;
  logic          cnt_hit;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign cnt_hit = (cnt_inc == CNT_HIT);

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    data_d   = data_q;
    start_d  = start_q;
    ack_d    = '0;
    done_d   = '0;
    terr_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d        = ISSUE;
          last_d         = sel_idx;
          gid_d          = sel_idx;
          data_d         = req_byte[sel_idx];
          ack_d[sel_idx] = 1'b1;
          start_d        = 1'b1;
          cnt_d          = '0;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        // tx_done_in is ignored here. The timeout has priority over a late busy,
        // so a stuck transfer cannot reach WAIT_DONE with a counter that is already expired.
        if (cnt_hit) begin
          start_d = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (tx_busy_in) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // Completion wins over a timeout in the same cycle
        if (tx_done_in) begin
          done_d[gid_q] = 1'b1;
          state_d       = IDLE;
        end else if (cnt_hit) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    active_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight byte
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= IDLE;
      last_q   <= LAST_RST;
      gid_q    <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      active_q <= 1'b0;
      terr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      active_q <= active_d;
      terr_q   <= terr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ack_out     = ack_q;
  assign req_done_out    = done_q;
  assign tx_data_out     = data_q;
  assign tx_start_out    = start_q;
  assign grant_id_out    = gid_q;
  assign active_out      = active_q;
  assign timeout_err_out = terr_q;

endmodule
